// File: rtl/tb_shaper_pkg.sv
// Shared TSN switch definitions for the token-bucket shaper: FSM encoding,
// token_bucket_para field layout, descriptor length width and token arithmetic.
package tb_shaper_pkg;

    localparam int FIELD_W      = 16;  // width of each token_bucket_para field
    localparam int DEPTH_LSB    = 16;  // bucket depth in bytes
    localparam int REFILL_LSB   = 0;   // refill bytes per interval
    localparam int MD_LEN_W     = 12;  // packet byte length carried in the descriptor
    localparam int TOKEN_W      = 17;
    localparam int TOKEN_CALC_W = 18;
    localparam int REFILL_W     = 16;
    localparam int CNT_W        = 64;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_TOKEN = 2'd1,
        ST_SEND       = 2'd2
    } shaper_state_e;

    // Next token count: add the refill, take the packet length, clamp to the
    // bucket depth. The floor at zero only matters if the depth or enable
    // changed while a descriptor was already released.
    function automatic logic [TOKEN_W-1:0] token_next(
        input logic [TOKEN_W-1:0]  cur,
        input logic [FIELD_W-1:0]  refill,
        input logic [FIELD_W-1:0]  depth,
        input logic [MD_LEN_W-1:0] len,
        input logic                deduct
    );
        logic [TOKEN_CALC_W-1:0] sum;
        sum = {1'b0, cur} + {2'b00, refill};
        if (deduct) begin
            sum = (sum >= {6'd0, len}) ? sum - {6'd0, len} : '0;
        end
        if (sum > {2'b00, depth}) begin
            sum = {2'b00, depth};
        end
        return sum[TOKEN_W-1:0];
    endfunction

endpackage

// File: rtl/tb_refill_timer.sv
// Free-running refill interval timer; wrap is high on the last cycle of each
// interval, which is the cycle the bucket receives its refill.
module tb_refill_timer
    import tb_shaper_pkg::*;
#(
    parameter logic [15:0] REFILL_CYCLES = 16'd125
) (
    input  logic clk,
    input  logic rst,
    output logic wrap
);

    logic [REFILL_W-1:0] count;

    assign wrap = (count == REFILL_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/tb_shaper.sv
// Token-bucket shaper: holds one descriptor at a time and releases it once the
// bucket holds at least its byte length (or immediately when shaping is off).
module tb_shaper
    import tb_shaper_pkg::*;
#(
    parameter logic [15:0] REFILL_CYCLES = 16'd125,
    parameter logic [7:0]  MD_LEN_LSB    = 8'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shaper_en,
    input  logic [31:0]        token_bucket_para,
    input  logic [31:0]        in_md,
    input  logic               in_md_valid,
    output logic               in_md_ready,
    output logic [31:0]        out_md,
    output logic               out_md_valid,
    input  logic               out_md_ready,
    output logic [TOKEN_W-1:0] tokens,
    output logic [CNT_W-1:0]   shaper_pass_cnt,
    output logic [CNT_W-1:0]   shaper_stall_cnt
);

    localparam int LEN_LSB = int'(MD_LEN_LSB);

    shaper_state_e        state, next_state;
    logic [31:0]          held_md;
    logic [MD_LEN_W-1:0]  held_len;
    logic [MD_LEN_W-1:0]  in_len;
    logic [FIELD_W-1:0]   depth;
    logic [FIELD_W-1:0]   refill;
    logic                 wrap;
    logic                 load;
    logic                 out_xfer;
    logic                 deduct;

    assign in_len = in_md[LEN_LSB +: MD_LEN_W];
    assign depth  = token_bucket_para[DEPTH_LSB +: FIELD_W];
    assign refill = token_bucket_para[REFILL_LSB +: FIELD_W];

    tb_refill_timer #(
        .REFILL_CYCLES (REFILL_CYCLES)
    ) u_refill_timer (
        .clk  (clk),
        .rst  (rst),
        .wrap (wrap)
    );

    // Both outputs come straight from flops, so the downstream path is registered.
    assign out_md       = held_md;
    assign out_md_valid = (state == ST_SEND);

    assign out_xfer = out_md_valid && out_md_ready;
    assign deduct   = out_xfer && shaper_en;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        in_md_ready = 1'b0;
        load        = 1'b0;
        case (state)
            ST_IDLE: begin
                in_md_ready = !rst;
                if (in_md_valid && !rst) begin
                    load = 1'b1;
                    if (!shaper_en || tokens >= {5'd0, in_len}) begin
                        next_state = ST_SEND;
                    end else begin
                        next_state = ST_WAIT_TOKEN;
                    end
                end
            end
            ST_WAIT_TOKEN: begin
                if (!shaper_en || tokens >= {5'd0, held_len}) begin
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_md_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            held_md          <= '0;
            held_len         <= '0;
            tokens           <= '0;
            shaper_pass_cnt  <= '0;
            shaper_stall_cnt <= '0;
        end else begin
            state  <= next_state;
            tokens <= token_next(tokens, wrap ? refill : '0, depth, held_len, deduct);
            if (load) begin
                held_md  <= in_md;
                held_len <= in_len;
            end
            if (out_xfer) begin
                shaper_pass_cnt <= shaper_pass_cnt + 64'd1;
            end
            if (state == ST_WAIT_TOKEN) begin
                shaper_stall_cnt <= shaper_stall_cnt + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_tb_shaper.sv
// Self-checking bench for tb_shaper: directed scenarios plus random traffic,
// compared every cycle against a transaction-level token-bucket model.
module tb_tb_shaper;

    localparam int N   = 125;
    localparam int LSB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        shaper_en;
    logic [31:0] token_bucket_para;
    logic [31:0] in_md;
    logic        in_md_valid;
    logic        in_md_ready;
    logic [31:0] out_md;
    logic        out_md_valid;
    logic        out_md_ready;
    logic [16:0] tokens;
    logic [63:0] shaper_pass_cnt;
    logic [63:0] shaper_stall_cnt;

    always #5 clk = ~clk;

    tb_shaper #(
        .REFILL_CYCLES (16'd125),
        .MD_LEN_LSB    (8'd4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .shaper_en         (shaper_en),
        .token_bucket_para (token_bucket_para),
        .in_md             (in_md),
        .in_md_valid       (in_md_valid),
        .in_md_ready       (in_md_ready),
        .out_md            (out_md),
        .out_md_valid      (out_md_valid),
        .out_md_ready      (out_md_ready),
        .tokens            (tokens),
        .shaper_pass_cnt   (shaper_pass_cnt),
        .shaper_stall_cnt  (shaper_stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one descriptor slot, a bucket count, and the phase of the
    // refill interval measured in cycles since reset.
    int              m_tokens;
    int              m_phase;
    bit              m_have;      // a descriptor is held
    bit              m_rel;       // the held descriptor is offered downstream
    logic [31:0]     m_md;
    int              m_len;
    longint unsigned m_pass;
    longint unsigned m_stall;
    bit              emitted;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [31:0] md);
        return int'((md >> LSB) & 32'hFFF);
    endfunction

    function automatic logic [31:0] make_md(input int len);
        logic [31:0] md;
        md = $urandom;
        md[LSB +: 12] = len[11:0];
        return md;
    endfunction

    task automatic model_edge();
        int  d, r, t;
        bit  wrap, in_x, out_x;
        if (rst) begin
            m_tokens = 0; m_phase = 0; m_have = 0; m_rel = 0;
            m_md = '0; m_len = 0; m_pass = 0; m_stall = 0;
            return;
        end
        d     = int'(token_bucket_para[31:16]);
        r     = int'(token_bucket_para[15:0]);
        wrap  = (m_phase == N - 1);
        in_x  = !m_have && in_md_valid;
        out_x = m_rel && out_md_ready;
        t = m_tokens + (wrap ? r : 0);
        if (out_x && shaper_en) t = (t >= m_len) ? t - m_len : 0;
        if (t > d) t = d;
        if (m_have && !m_rel) m_stall++;
        if (out_x) begin
            m_have = 0; m_rel = 0; m_pass++;
        end else if (m_have && !m_rel && (!shaper_en || m_tokens >= m_len)) begin
            m_rel = 1;
        end
        if (in_x) begin
            m_have = 1;
            m_md   = in_md;
            m_len  = len_of(in_md);
            m_rel  = !shaper_en || (m_tokens >= m_len);
        end
        m_tokens = t;
        m_phase  = (m_phase + 1) % N;
    endtask

    // One clock: check the combinational ready, advance the model, then check
    // every registered output shortly after the edge.
    task automatic step();
        #1;
        check("in_md_ready", in_md_ready, !rst && !m_have);
        model_edge();
        @(posedge clk);
        #1;
        check("out_md_valid", out_md_valid, m_rel);
        if (m_rel) check("out_md", out_md, m_md);
        check("tokens", tokens, m_tokens);
        check("pass_cnt", shaper_pass_cnt, m_pass);
        check("stall_cnt", shaper_stall_cnt, m_stall);
        if (out_md_valid) emitted = 1;
    endtask

    task automatic idle(input int n);
        in_md_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_md_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int guard;
        rst = 1'b1;
        shaper_en = 1'b1;
        token_bucket_para = {16'd3000, 16'd100};
        in_md = '0;
        in_md_valid = 1'b0;
        out_md_ready = 1'b1;
        emitted = 0;

        // Reset state
        do_reset();
        check("rst_out_md", out_md, 32'd0);
        check("rst_tokens", tokens, 64'd0);

        // Shaping off: four 1500-byte descriptors stream through, no tokens used
        shaper_en = 1'b0;
        begin
            int sent;
            sent = 0;
            for (int i = 0; i < 8; i++) begin
                in_md_valid = (sent < 4);
                if (!m_have) in_md = make_md(1500);
                if (!m_have && in_md_valid) sent++;
                step();
            end
        end
        in_md_valid = 1'b0;
        check("bypass_pass4", shaper_pass_cnt, 64'd4);
        check("bypass_tokens0", tokens, 64'd0);

        // From reset, L=500 with R=100 waits for the fifth refill
        do_reset();
        shaper_en = 1'b1;
        token_bucket_para = {16'd3000, 16'd100};
        in_md = make_md(500);
        in_md_valid = 1'b1;
        step();
        in_md_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 800; i++) begin
            step();
            if (out_md_valid) begin
                lat = i;
                break;
            end
        end
        check("l500_release_cycle", lat, 625);
        step();
        check("l500_tokens_after", tokens, 64'd0);
        check("l500_pass", shaper_pass_cnt, 64'd1);

        // Saturation at the bucket depth
        idle(4000);
        check("full_tokens", tokens, 64'd3000);
        idle(1000);
        check("full_hold", tokens, 64'd3000);

        // Descriptor accepted on a refill cycle: refill and deduction both land
        do_reset();
        token_bucket_para = {16'd3000, 16'd50};
        guard = 0;
        while (!(m_phase == N - 1 && m_tokens == 100) && guard < 1000) begin
            step();
            guard++;
        end
        check("wrap_setup_found", guard < 1000, 1'b1);
        in_md = make_md(100);
        in_md_valid = 1'b1;
        step();
        in_md_valid = 1'b0;
        step();
        check("wrap_tokens50", tokens, 64'd50);

        // Depth lowered below the current count clamps on the next cycle
        do_reset();
        token_bucket_para = {16'd3000, 16'd1000};
        guard = 0;
        while (m_tokens != 2000 && guard < 1000) begin
            step();
            guard++;
        end
        check("depth_setup_tokens", tokens, 64'd2000);
        token_bucket_para = {16'd1000, 16'd1000};
        step();
        check("depth_clamp", tokens, 64'd1000);

        // Zero-length descriptor passes with an empty bucket
        do_reset();
        token_bucket_para = {16'd3000, 16'd0};
        in_md = make_md(0);
        in_md_valid = 1'b1;
        step();
        in_md_valid = 1'b0;
        check("zero_len_valid", out_md_valid, 1'b1);
        step();

        // Oversize descriptor stalls, then reset discards it
        do_reset();
        token_bucket_para = {16'd1000, 16'd200};
        in_md = make_md(1500);
        in_md_valid = 1'b1;
        step();
        in_md_valid = 1'b0;
        emitted = 0;
        idle(300);
        check("oversize_stalls", shaper_stall_cnt, 64'd300);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", out_md_valid, 1'b0);
        check("rst_mid_tokens", tokens, 64'd0);
        check("rst_mid_stall", shaper_stall_cnt, 64'd0);
        check("rst_mid_pass", shaper_pass_cnt, 64'd0);
        idle(200);
        check("rst_mid_never_emitted", emitted, 1'b0);

        // Shaping switched off while waiting releases without deduction
        do_reset();
        token_bucket_para = {16'd3000, 16'd100};
        in_md = make_md(700);
        in_md_valid = 1'b1;
        step();
        in_md_valid = 1'b0;
        idle(130);
        shaper_en = 1'b0;
        step();
        check("en_drop_release", out_md_valid, 1'b1);
        step();
        check("en_drop_tokens", tokens, 64'd100);
        shaper_en = 1'b1;

        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 199) == 0) shaper_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                token_bucket_para[31:16] = 16'($urandom_range(0, 3000));
                token_bucket_para[15:0]  = 16'($urandom_range(0, 400));
            end
            in_md_valid  = $urandom_range(0, 1);
            in_md        = make_md($urandom_range(0, 700));
            out_md_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
